// File: rtl/stoplight_pkg.sv
// Shared types and helpers for the stoplight sequencer and its lamp decoder.
package stoplight_pkg;

  // Colour code, also the encoding presented on the phase output.
  typedef enum logic [1:0] {
    COL_NONE = 2'b00,
    COL_R    = 2'b01,
    COL_G    = 2'b10,
    COL_Y    = 2'b11
  } colour_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DWELL,
    ST_REQ,
    ST_WAIT_CHG,
    ST_FAULT
  } seq_state_t;

  // Remaining green dwell allowed once a pedestrian request is seen.
  localparam int unsigned PED_TRUNC = 2;

  // Legal successor in the R -> G -> Y -> R cycle.
  function automatic colour_t next_colour(input colour_t c);
    colour_t n;
    case (c)
      COL_R:   n = COL_G;
      COL_G:   n = COL_Y;
      COL_Y:   n = COL_R;
      default: n = COL_NONE;
    endcase
    return n;
  endfunction

  // Lamp vector is {r, y, g}; anything other than exactly one lamp is NONE.
  function automatic colour_t lamps_to_colour(input logic [2:0] ryg);
    colour_t c;
    case (ryg)
      3'b100:  c = COL_R;
      3'b001:  c = COL_G;
      3'b010:  c = COL_Y;
      default: c = COL_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/stoplight_sequencer_lamp_decode.sv
// Registers the lamp inputs once and decodes them into a colour code.
module stoplight_lamp_decode
  import stoplight_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       r,
  input  logic       y,
  input  logic       g,
  output colour_t    colour,
  output logic       one_hot,
  output logic [1:0] phase
);

  logic [2:0] lamp_q;

  // Sample {r,y,g} every cycle; all sequencer decisions use this copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lamp_q <= '0;
    else        lamp_q <= {r, y, g};
  end

  // Decode the sampled lamps; NONE doubles as the not-one-hot indication.
  always_comb begin
    colour  = lamps_to_colour(lamp_q);
    one_hot = (colour != COL_NONE);
    phase   = colour;
  end

endmodule

// File: rtl/stoplight_sequencer.sv
// Stoplight sequencer: holds each colour for its dwell, pulses start to the
// light FSM, and checks that the light follows R -> G -> Y -> R.
// Optional macro STOPLIGHT_PED_REQ_EN adds a ped_req input that shortens the
// green dwell.
module stoplight_sequencer
  import stoplight_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned R_DWELL     = 20,
  parameter int unsigned G_DWELL     = 16,
  parameter int unsigned Y_DWELL     = 4,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr_err,
`ifdef STOPLIGHT_PED_REQ_EN
  input  logic       ped_req,
`endif
  input  logic       r,
  input  logic       y,
  input  logic       g,
  output logic       start,
  output logic [1:0] phase,
  output logic       busy,
  output logic       err_onehot,
  output logic       err_order,
  output logic       err_timeout
);

  localparam logic [CNT_W-1:0] ACK_LIM = CNT_W'(ACK_TIMEOUT);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec, cnt_step;
  logic [CNT_W-1:0] tcnt_q, tcnt_d, tcnt_inc;
  colour_t          prev_q, prev_d;
  colour_t          colour;
  logic             one_hot;
  logic             start_d;
  logic             set_onehot, set_order, set_timeout;

  stoplight_lamp_decode u_decode (
    .clk     (clk),
    .rst_n   (rst_n),
    .r       (r),
    .y       (y),
    .g       (g),
    .colour  (colour),
    .one_hot (one_hot),
    .phase   (phase)
  );

  function automatic logic [CNT_W-1:0] dwell_load(input colour_t c);
    logic [CNT_W-1:0] v;
    case (c)
      COL_R:   v = CNT_W'(R_DWELL - 1);
      COL_G:   v = CNT_W'(G_DWELL - 1);
      COL_Y:   v = CNT_W'(Y_DWELL - 1);
      default: v = '0;
    endcase
    return v;
  endfunction

  // Saturating counter arithmetic.
  always_comb begin
    cnt_dec  = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
    tcnt_inc = (tcnt_q == '1) ? tcnt_q : tcnt_q + 1'b1;
  end

`ifdef STOPLIGHT_PED_REQ_EN
  localparam logic [CNT_W-1:0] PED_CNT = CNT_W'(PED_TRUNC);

  // Pedestrian request on green: step as though the counter held PED_CNT.
  always_comb begin
    if (ped_req && (prev_q == COL_G) && (cnt_q > PED_CNT)) cnt_step = PED_CNT - 1'b1;
    else                                                    cnt_step = cnt_dec;
  end
`else
  // Full dwell always.
  always_comb cnt_step = cnt_dec;
`endif

  // Next-state, counter and error-detect logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tcnt_d      = tcnt_q;
    prev_d      = prev_q;
    start_d     = 1'b0;
    set_onehot  = 1'b0;
    set_order   = 1'b0;
    set_timeout = 1'b0;

    if (state_q == ST_FAULT) begin
      if (clr_err) state_d = ST_IDLE;
    end else if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (one_hot) begin
            state_d = ST_DWELL;
            cnt_d   = dwell_load(colour);
            prev_d  = colour;
          end else begin
            set_onehot = 1'b1;
          end
        end
        ST_DWELL: begin
          if (!one_hot)                set_onehot = 1'b1;
          else if (colour != prev_q)   set_order  = 1'b1;
          else if (cnt_q == '0) begin
            state_d = ST_REQ;
            start_d = 1'b1;
          end else begin
            cnt_d = cnt_step;
          end
        end
        ST_REQ: begin
          tcnt_d  = '0;
          state_d = ST_WAIT_CHG;
        end
        ST_WAIT_CHG: begin
          tcnt_d = tcnt_inc;
          if (!one_hot) begin
            set_onehot = 1'b1;
          end else if (colour == prev_q) begin
            if (tcnt_inc >= ACK_LIM) set_timeout = 1'b1;
          end else if (colour == next_colour(prev_q)) begin
            state_d = ST_DWELL;
            cnt_d   = dwell_load(colour);
            prev_d  = colour;
          end else begin
            set_order = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      // A same-cycle clr_err suppresses the new fault entirely.
      if (set_onehot || set_order || set_timeout)
        state_d = clr_err ? ST_IDLE : ST_FAULT;
    end
  end

  // State, counters, registered start and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      prev_q      <= COL_NONE;
      start       <= 1'b0;
      err_onehot  <= 1'b0;
      err_order   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      prev_q      <= prev_d;
      start       <= start_d;
      err_onehot  <= clr_err ? 1'b0 : (err_onehot  | set_onehot);
      err_order   <= clr_err ? 1'b0 : (err_order   | set_order);
      err_timeout <= clr_err ? 1'b0 : (err_timeout | set_timeout);
    end
  end

  // Busy while a colour is being timed or a change is pending.
  always_comb busy = state_q inside {ST_DWELL, ST_REQ, ST_WAIT_CHG};

endmodule
